// File: rtl/i2s_tx_serializer.sv
// I2S (Philips) slave transmitter: one-pair input buffer, MSB-first shifter timed by external sck/ws.
// Optional saturating underrun counter built when I2S_TX_UNDERRUN_CNT_EN is defined.
module i2s_tx_serializer #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sck_i,
    input  logic          ws_i,
    input  logic [DW-1:0] in_l,
    input  logic [DW-1:0] in_r,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          sd_o,
    output logic          sample_req,
    output logic          underrun,
    output logic [7:0]    underrun_cnt
);
    localparam int CW = $clog2(DW + 1);

    logic [1:0]    sck_sync, ws_sync;
    logic          sck_s, ws_s, sck_q, rise, fall;
    logic          ws_lat, ws_chg, buf_full;
    logic [DW-1:0] buf_l, buf_r, shr, r_hold;
    logic [CW-1:0] bitcnt;

    assign sck_s    = sck_sync[1];
    assign ws_s     = ws_sync[1];
    assign rise     = sck_s & ~sck_q;
    assign fall     = ~sck_s & sck_q;
    assign in_ready = ~buf_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync <= '0;
            ws_sync  <= '0;
            sck_q    <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[0], sck_i};
            ws_sync  <= {ws_sync[0], ws_i};
            sck_q    <= sck_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ws_lat     <= 1'b0;
            ws_chg     <= 1'b0;
            buf_full   <= 1'b0;
            buf_l      <= '0;
            buf_r      <= '0;
            shr        <= '0;
            r_hold     <= '0;
            bitcnt     <= '0;
            sd_o       <= 1'b0;
            sample_req <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            sample_req <= 1'b0;
            underrun   <= 1'b0;
            // Buffer is only writable while empty, so a write never races a consume.
            if (in_valid && in_ready) begin
                buf_l    <= in_l;
                buf_r    <= in_r;
                buf_full <= 1'b1;
            end
            if (rise) begin
                ws_lat <= ws_s;
                ws_chg <= (ws_s != ws_lat);
            end else if (fall) begin
                if (ws_chg) begin
                    ws_chg <= 1'b0;
                    bitcnt <= CW'(1);
                    if (ws_lat) begin
                        shr  <= r_hold;
                        sd_o <= r_hold[DW-1];
                    end else if (buf_full) begin
                        shr        <= buf_l;
                        r_hold     <= buf_r;
                        buf_full   <= 1'b0;
                        sd_o       <= buf_l[DW-1];
                        sample_req <= 1'b1;
                    end else begin
                        // Nothing to send: mute both slots of this frame.
                        shr      <= '0;
                        r_hold   <= '0;
                        sd_o     <= 1'b0;
                        underrun <= 1'b1;
                    end
                end else if (bitcnt < CW'(DW)) begin
                    shr    <= shr << 1;
                    sd_o   <= shr[DW-2];
                    bitcnt <= bitcnt + CW'(1);
                end else begin
                    sd_o <= 1'b0;
                end
            end
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [7:0] ucnt;
    always_ff @(posedge clk) begin
        if (rst)
            ucnt <= 8'h00;
        else if (underrun && ucnt != 8'hFF)
            ucnt <= ucnt + 8'h01;
    end
    assign underrun_cnt = ucnt;
`else
    assign underrun_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: bench-side I2S master/receiver, frame tables and random frames.
module tb_i2s_tx_serializer;
    logic       clk, rst, sck_i, ws_i, in_valid;
    logic [7:0] in_l, in_r;
    logic       in_ready, sd_o, sample_req, underrun;
    logic [7:0] underrun_cnt;

    i2s_tx_serializer #(.DW(8)) dut (
        .clk(clk), .rst(rst), .sck_i(sck_i), .ws_i(ws_i),
        .in_l(in_l), .in_r(in_r), .in_valid(in_valid), .in_ready(in_ready),
        .sd_o(sd_o), .sample_req(sample_req), .underrun(underrun),
        .underrun_cnt(underrun_cnt)
    );

    typedef struct {
        bit         push;
        logic [7:0] l, r;
        int         len_l, len_r;
        logic [7:0] exp_l, exp_r;
    } row_t;

    typedef struct {
        logic [31:0] lw, rw;
        int          ln, rn;
    } cap_t;

    int   errors = 0, checks = 0;
    int   len_l = 8, len_r = 8;
    int   ur_seen = 0, req_seen = 0;
    time  req_t = 0, xfer_t = 0;
    row_t rows[$];
    cap_t cap_q[$];

`ifdef I2S_TX_UNDERRUN_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // I2S master: sck period 8 clk, ws toggles together with the last sck fall of a slot.
    initial begin
        int glen;
        sck_i = 1'b0;
        ws_i  = 1'b0;
        forever begin
            glen = ws_i ? len_r : len_l;
            for (int b = 0; b < glen; b++) begin
                #40 sck_i = 1'b1;
                #40 sck_i = 1'b0;
            end
            ws_i = ~ws_i;
        end
    end

    // Receiver: the bit taken on the rise that first sees a new ws is the previous word's LSB.
    initial begin
        logic [31:0] acc, lw;
        int          n, ln;
        logic        rx_ws;
        acc = 0; lw = 0; n = 0; ln = 0; rx_ws = 1'b0;
        forever begin
            @(posedge sck_i);
            acc = (acc << 1) | 32'(sd_o);
            n++;
            if (ws_i != rx_ws) begin
                if (!rx_ws) begin
                    lw = acc;
                    ln = n;
                end else begin
                    cap_q.push_back('{lw, acc, ln, n});
                end
                rx_ws = ws_i;
                acc = 0;
                n = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (underrun) ur_seen <= ur_seen + 1;
        if (sample_req) begin
            req_seen <= req_seen + 1;
            req_t    <= $time;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] l, input logic [7:0] r);
        int k;
        @(negedge clk);
        in_l = l; in_r = r; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL push timeout: in_ready stayed 0 for %0d clk", k);
        end else begin
            xfer_t = $time;
        end
        @(posedge clk);
    endtask

    task automatic wait_caps(input int need);
        int k;
        k = 0;
        while (cap_q.size() < need && k < 3000) begin
            @(posedge clk);
            k++;
        end
        if (cap_q.size() < need) begin
            checks++;
            errors++;
            $display("FAIL capture timeout: got %0d frames need %0d", cap_q.size(), need);
        end
    endtask

    // One row per frame; the pair is offered mid right slot so the next left slot consumes it.
    task automatic run_frames(input string tag);
        int         n, np, ur0, rq0;
        logic [7:0] cnt0;
        n = rows.size();
        np = 0;
        @(posedge ws_i);
        repeat (20) @(posedge clk);
        cap_q.delete();
        ur0 = ur_seen; rq0 = req_seen; cnt0 = underrun_cnt;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(posedge ws_i);
                repeat (20) @(posedge clk);
            end
            len_l = rows[i].len_l;
            len_r = rows[i].len_r;
            if (rows[i].push) begin
                np++;
                push(rows[i].l, rows[i].r);
                @(negedge clk);
                in_valid = 1'b0;
            end
        end
        wait_caps(n + 1);
        for (int i = 0; i < n && i + 1 < cap_q.size(); i++) begin
            chk($sformatf("%s frame%0d L", tag, i), {32'(cap_q[i+1].ln), cap_q[i+1].lw},
                {32'(rows[i].len_l), 32'(rows[i].exp_l) << (rows[i].len_l - 8)});
            chk($sformatf("%s frame%0d R", tag, i), {32'(cap_q[i+1].rn), cap_q[i+1].rw},
                {32'(rows[i].len_r), 32'(rows[i].exp_r) << (rows[i].len_r - 8)});
        end
        chk({tag, " sample_req pulses"}, 64'(req_seen - rq0), 64'(np));
        chk({tag, " underrun pulses"}, 64'(ur_seen - ur0), 64'(n - np));
        chk({tag, " underrun_cnt delta"}, 64'(8'(underrun_cnt - cnt0)), CNT_EN ? 64'(n - np) : 64'd0);
        len_l = 8;
        len_r = 8;
    endtask

    initial begin
        row_t tbl[8];
        int   ur0, rq0, k;
        logic ws0, bad;
        logic [7:0] a, b;

        tbl[0] = '{1'b1, 8'hA5, 8'h3C, 8,  8, 8'hA5, 8'h3C};
        tbl[1] = '{1'b0, 8'h12, 8'h34, 8,  8, 8'h00, 8'h00};
        tbl[2] = '{1'b0, 8'h56, 8'h78, 8,  8, 8'h00, 8'h00};
        tbl[3] = '{1'b0, 8'h9A, 8'hBC, 8,  8, 8'h00, 8'h00};
        tbl[4] = '{1'b1, 8'h01, 8'h80, 8,  8, 8'h01, 8'h80};
        tbl[5] = '{1'b1, 8'h7F, 8'hFE, 8,  8, 8'h7F, 8'hFE};
        tbl[6] = '{1'b1, 8'hFF, 8'h81, 12, 8, 8'hFF, 8'h81};
        tbl[7] = '{1'b1, 8'h5A, 8'hC3, 8,  8, 8'h5A, 8'hC3};

        rst = 1'b1; in_valid = 1'b0; in_l = 8'h00; in_r = 8'h00;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (300) @(posedge clk);

        // Reset mid right slot with a pair buffered.
        @(posedge ws_i);
        repeat (20) @(posedge clk);
        push(8'h11, 8'h22);
        @(negedge clk);
        in_valid = 1'b0;
        chk("in_ready low while full", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset sd_o", 64'(sd_o), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset sample_req", 64'(sample_req), 64'd0);
        chk("reset underrun", 64'(underrun), 64'd0);
        chk("reset underrun_cnt", 64'(underrun_cnt), 64'd0);
        ws0 = ws_i; bad = 1'b0; k = 0;
        while (ws_i == ws0 && k < 400) begin
            @(negedge clk);
            if (sd_o) bad = 1'b1;
            k++;
        end
        chk("sd_o quiet until ws edge", 64'(bad), 64'd0);
        ur0 = ur_seen; rq0 = req_seen;
        repeat (30) @(posedge clk);
        chk("post-reset left underrun", 64'(ur_seen - ur0), 64'd1);
        chk("post-reset no sample_req", 64'(req_seen - rq0), 64'd0);

        for (int i = 0; i < 8; i++) rows.push_back(tbl[i]);
        run_frames("table");

        // Back-to-back pairs with in_valid held high across the consume.
        @(posedge ws_i);
        repeat (20) @(posedge clk);
        cap_q.delete();
        push(8'h01, 8'h80);
        push(8'h7F, 8'hFE);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b transfer 1 clk after consume", 64'((xfer_t + 5) - (req_t - 5)), 64'd10);
        wait_caps(3);
        if (cap_q.size() >= 3) begin
            chk("b2b frame0", {cap_q[1].lw, cap_q[1].rw}, {32'h01, 32'h80});
            chk("b2b frame1", {cap_q[2].lw, cap_q[2].rw}, {32'h7F, 32'hFE});
        end

        // Random frames: a frame carries the pair offered just before it, otherwise silence.
        rows.delete();
        for (int i = 0; i < 16; i++) begin
            row_t rw;
            a = 8'($urandom);
            b = 8'($urandom);
            rw.push  = ($urandom_range(0, 3) != 0);
            rw.l     = a;
            rw.r     = b;
            rw.len_l = $urandom_range(8, 11);
            rw.len_r = $urandom_range(8, 11);
            rw.exp_l = rw.push ? a : 8'h00;
            rw.exp_r = rw.push ? b : 8'h00;
            rows.push_back(rw);
        end
        run_frames("random");

        // Long underrun run: counter must saturate (or stay tied low).
        repeat (300) @(negedge ws_i);
        repeat (40) @(posedge clk);
        chk("underrun_cnt saturation", 64'(underrun_cnt), CNT_EN ? 64'hFF : 64'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
